gate_exerciser: RTL
===================

// Module: gate_exerciser
// PURPOSE
//  Self-checking stimulus/response partner for the two-input logic-gate unit.
//  Drives A/B through all four input vectors and samples the seven gate outputs after a settle delay.
//  Compares each sample against a golden truth table and reports pass/fail, a per-gate error mask and the first failing vector.
//  Used as the on-board/bench checker for the gate unit.
// PARAMETERS
//  SETTLE_CYCLES  2       cycles A/B are held before sampling; legal range 1..(2**CNT_W-1)
//  CNT_W          4       settle counter width
//  GATE_MASK      7'h7F   1 = gate is checked; masked gates never raise errors
// PORTS
//  clk       in   1  system clock, rising edge
//  rst_n     in   1  asynchronous active-low reset
//  start     in   1  level; sampled only in IDLE, begins a run
//  gate_i    in   7  DUT outputs {XNOR,XOR,NOT,NOR,OR,NAND,AND}, bit6..bit0
//  a_o       out  1  stimulus A to DUT (registered)
//  b_o       out  1  stimulus B to DUT (registered)
//  busy      out  1  high from run start until DONE exits
//  done      out  1  one-cycle pulse, run complete
//  pass      out  1  (err_vec==0); valid from done until next start
//  err_vec   out  7  sticky per-gate mismatch mask, same bit order as gate_i
//  err_cnt   out  3  number of vectors with >=1 mismatch (0..4)
//  fail_idx  out  2  first failing vector index {A,B}; 0 if none
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; a_o=b_o=0; busy=done=pass=0; err_vec=0; err_cnt=0; fail_idx=0; vec=0.
//  Golden: AND=A&B, NAND=~(A&B), OR=A|B, NOR=~(A|B), NOT=~A (single input, B ignored), XOR=A^B, XNOR=~(A^B).
//  Vector order: vec=0,1,2,3 with A=vec[1], B=vec[0].
//  FSM: IDLE -> SETTLE -> CHECK -> (SETTLE | DONE) -> IDLE.
//   IDLE: start=1 -> SETTLE; vec=0; a_o/b_o=00; busy=1; clear err_vec/err_cnt/fail_idx/pass.
//   SETTLE: hold a_o/b_o for SETTLE_CYCLES cycles (counter loaded on entry) -> CHECK.
//   CHECK (1 cycle): mism = (gate_i ^ golden(vec)) & GATE_MASK; err_vec |= mism;
//     if mism!=0: err_cnt++, and if err_cnt==0 beforehand, fail_idx=vec.
//     vec<3: vec++, drive new a_o/b_o, -> SETTLE.  vec==3: -> DONE.
//   DONE (1 cycle): done=1, pass=(err_vec==0), busy=1; -> IDLE (busy=0).
//  Latency: counting the start-sampling edge as edge 0, done rises on edge 4*(SETTLE_CYCLES+1); with default SETTLE_CYCLES=2 -> edge 12.
//  start in SETTLE/CHECK/DONE ignored. start held high -> new run begins on the first IDLE cycle, one idle cycle between runs.
//  a_o/b_o stay at 11 after a run until the next start or reset.
//  err_cnt saturates naturally at 4 (3 bits, max 4 vectors); no wrap.
//  gate_i sampled only in CHECK; changes at any other time have no effect.
//  rst_n low mid-run: immediate abort to reset values, no done pulse; the next start runs a full sequence.
// STRUCTURE
//  Include gate_exerciser_defs.vh: state encodings (IDLE, SETTLE, CHECK, DONE), gate bit-index localparams (AND=0..XNOR=6).
//  Sub-module gate_golden: combinational (a,b) -> 7-bit expected vector.
//   Instantiated once; also reusable as the bench reference model.
//  Top holds FSM, vec counter, settle counter, result registers.
// TESTING
//  1 Correct gate model on gate_i, defaults, start pulse -> done at edge 12, pass=1, err_vec=0, err_cnt=0, fail_idx=0.
//  2 NOT wired as ~(A|B) -> only vec=1 fails: err_vec=7'h10, err_cnt=1, fail_idx=2'b01, pass=0.
//  3 gate_i stuck at 7'h00 -> err_vec=7'h7F, err_cnt=4, fail_idx=0, pass=0.
//  4 GATE_MASK=7'h6F with the same NOT fault -> pass=1, err_vec=0.
//  5 rst_n=0 during vec=2 SETTLE -> all outputs return to reset values at once, no done pulse;
//    a later start gives a full 12-edge run with pass=1.
//  6 start held high across two runs, fault only in the first run -> second run reports err_vec=0, pass=1 (results cleared at start).

Source files
------------

// File: rtl/gate_exerciser_pkg.sv
// Shared definitions for the gate exerciser: FSM state encoding and the bit
// position of each gate within the 7-bit gate vector.
package gate_exerciser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int NUM_GATES = 7;

  localparam int GATE_AND  = 0;
  localparam int GATE_NAND = 1;
  localparam int GATE_OR   = 2;
  localparam int GATE_NOR  = 3;
  localparam int GATE_NOT  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  localparam int NUM_VECS = 4;

endpackage

// File: rtl/gate_exerciser_golden.sv
// Golden truth table for the two-input gate unit.
// Ports:
//   a_i, b_i  : stimulus inputs
//   gold_o    : expected gate outputs {XNOR,XOR,NOT,NOR,OR,NAND,AND}
module gate_exerciser_golden
  import gate_exerciser_pkg::*;
(
  input  logic                 a_i,
  input  logic                 b_i,
  output logic [NUM_GATES-1:0] gold_o
);

  always_comb begin
    gold_o            = '0;
    gold_o[GATE_AND]  = a_i & b_i;
    gold_o[GATE_NAND] = ~(a_i & b_i);
    gold_o[GATE_OR]   = a_i | b_i;
    gold_o[GATE_NOR]  = ~(a_i | b_i);
    gold_o[GATE_NOT]  = ~a_i;  // single-input gate, B does not participate
    gold_o[GATE_XOR]  = a_i ^ b_i;
    gold_o[GATE_XNOR] = ~(a_i ^ b_i);
  end

endmodule

// File: rtl/gate_exerciser.sv
// Stimulus/response checker for the two-input gate unit. Steps A/B through
// the four input vectors, waits SETTLE_CYCLES per vector, then compares the
// seven gate outputs against the golden table.
// Ports:
//   clk, rst_n  : clock (rising edge), async active-low reset
//   start       : level, sampled only in IDLE, begins a run
//   gate_i      : gate unit outputs {XNOR,XOR,NOT,NOR,OR,NAND,AND}
//   a_o, b_o    : registered stimulus to the gate unit
//   busy        : high from run start until DONE exits
//   done        : one-cycle completion pulse
//   pass        : no mismatches in last run; valid from done to next start
//   err_vec     : sticky per-gate mismatch mask
//   err_cnt     : number of vectors with at least one mismatch
//   fail_idx    : first failing vector {A,B}, 0 if none
//
// state  | meaning
// IDLE   | waiting for start; results of last run held
// SETTLE | A/B driven, counting down settle time
// CHECK  | one cycle: compare gate_i with golden, advance vector
// DONE   | one cycle: done pulse, pass valid
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int                   SETTLE_CYCLES = 2,
  parameter int                   CNT_W         = 4,
  parameter logic [NUM_GATES-1:0] GATE_MASK     = 7'h7F
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_GATES-1:0] gate_i,
  output logic                 a_o,
  output logic                 b_o,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] err_vec,
  output logic [2:0]           err_cnt,
  output logic [1:0]           fail_idx
);

  // Counter counts down to zero, so SETTLE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t               state_q, state_d;
  logic [1:0]           vec_q, vec_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_GATES-1:0] err_vec_q, err_vec_d;
  logic [2:0]           err_cnt_q, err_cnt_d;
  logic [1:0]           fail_idx_q, fail_idx_d;
  logic                 pass_q, pass_d;

  logic [NUM_GATES-1:0] gold;
  logic [NUM_GATES-1:0] mism;

  gate_exerciser_golden u_golden (
    .a_i    (vec_q[1]),
    .b_i    (vec_q[0]),
    .gold_o (gold)
  );

  assign mism = (gate_i ^ gold) & GATE_MASK;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    err_vec_d  = err_vec_q;
    err_cnt_d  = err_cnt_q;
    fail_idx_d = fail_idx_q;
    pass_d     = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          vec_d      = 2'd0;
          cnt_d      = CNT_LOAD;
          err_vec_d  = '0;
          err_cnt_d  = '0;
          fail_idx_d = '0;
          pass_d     = 1'b0;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_CHECK: begin
        err_vec_d = err_vec_q | mism;
        if (mism != '0) begin
          // At most four vectors, so the 3-bit count never wraps.
          err_cnt_d = err_cnt_q + 3'd1;
          if (err_cnt_q == '0) begin
            fail_idx_d = vec_q;
          end
        end
        if (vec_q != 2'd3) begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = CNT_LOAD;
          state_d = ST_SETTLE;
        end else begin
          // Registered here so pass is valid in the same cycle as done.
          pass_d  = (err_vec_d == '0);
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= 2'd0;
      cnt_q      <= '0;
      err_vec_q  <= '0;
      err_cnt_q  <= '0;
      fail_idx_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      err_vec_q  <= err_vec_d;
      err_cnt_q  <= err_cnt_d;
      fail_idx_q <= fail_idx_d;
      pass_q     <= pass_d;
    end
  end

  // The vector register doubles as the stimulus; it rests at 11 after a run.
  assign a_o      = vec_q[1];
  assign b_o      = vec_q[0];
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign pass     = pass_q;
  assign err_vec  = err_vec_q;
  assign err_cnt  = err_cnt_q;
  assign fail_idx = fail_idx_q;

endmodule
